// File: rtl/areg_wr_arb_pkg.sv
// Shared types and constants for the areg write-port arbiter slice.
package areg_wr_arb_pkg;

  localparam int NREGS       = 16;
  localparam int AREG_AW     = $clog2(NREGS);
  localparam int AREG_MIRROR = 8;
  localparam int AREG_WIDTH  = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/areg_wr_arb_if.sv
// Requester-side handshake plus the write bus driven into areg.
interface areg_wr_arb_if
  import areg_wr_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = AREG_WIDTH
) ();

  logic                      en;
  logic [NREQ-1:0]           req_v;
  logic [NREQ-1:0]           req_y;
  logic [NREQ-1:0]           req_lock;
  logic [NREQ*AREG_AW-1:0]   req_wa;
  logic [NREQ*WIDTH-1:0]     req_wval;
  logic [NREQ-1:0]           req_rdy;
  logic                      areg_w;
  logic                      areg_y;
  logic [AREG_AW-1:0]        areg_wa;
  logic [WIDTH-1:0]          areg_wval;
  logic [$clog2(NREQ)-1:0]   owner;
  logic                      locked;

  modport master (
    output en, req_v, req_y, req_lock, req_wa, req_wval,
    input  req_rdy, areg_w, areg_y, areg_wa, areg_wval, owner, locked
  );

  modport slave (
    input  en, req_v, req_y, req_lock, req_wa, req_wval,
    output req_rdy, areg_w, areg_y, areg_wa, areg_wval, owner, locked
  );

endinterface

// File: rtl/areg_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set mask bit after ptr, wrapping.
module areg_wr_arb_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         mask,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  // Scan ptr+1, ptr+2, ... and keep the first candidate found.
  always_comb begin
    logic [PW-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!any && mask[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/areg_wr_arb.sv
// Round-robin arbiter with bounded lock for the single areg write port.
// The winning request is registered once and presented to areg next cycle.
module areg_wr_arb
  import areg_wr_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = AREG_WIDTH,
  parameter int LOCK_MAX = 8
) (
  input logic          clk,
  input logic          rst,
  areg_wr_arb_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

  arb_state_t           state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                 areg_w_q, areg_w_d;
  logic                 areg_y_q, areg_y_d;
  logic [AREG_AW-1:0]   areg_wa_q, areg_wa_d;
  logic [WIDTH-1:0]     areg_wval_q, areg_wval_d;

  logic [NREQ-1:0]      pick_mask, pick_grant, rdy;
  logic [PW-1:0]        pick_idx, sel;
  logic                 pick_any, hold_mode, expire_mode;
  logic                 sel_y;
  logic [AREG_AW-1:0]   sel_wa;
  logic [WIDTH-1:0]     sel_wval;

  // Lock sub-modes: owner-only while the lock is kept and unexpired; owner
  // excluded from the open arbitration in the cycle the lock times out.
  always_comb begin
    hold_mode   = (state_q == ARB_LOCKED) && bus.req_lock[owner_q] && (lock_cnt_q < LOCK_MAX_C);
    expire_mode = (state_q == ARB_LOCKED) && (lock_cnt_q >= LOCK_MAX_C);
    pick_mask   = bus.req_v;
    if (expire_mode) pick_mask[owner_q] = 1'b0;
  end

  areg_wr_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .mask  (pick_mask),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Mux the selected requester's write fields (owner while holding, else winner).
  always_comb begin
    sel      = hold_mode ? owner_q : pick_idx;
    sel_y    = 1'b0;
    sel_wa   = '0;
    sel_wval = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == PW'(i)) begin
        sel_y    = bus.req_y[i];
        sel_wa   = bus.req_wa[AREG_AW*i +: AREG_AW];
        sel_wval = bus.req_wval[WIDTH*i +: WIDTH];
      end
    end
  end

  // Grant decision and next-state; grants are suppressed during reset so no
  // requester believes a transfer happened that the flops will discard.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    lock_cnt_d  = lock_cnt_q;
    areg_w_d    = 1'b0;
    areg_y_d    = areg_y_q;
    areg_wa_d   = areg_wa_q;
    areg_wval_d = areg_wval_q;
    rdy         = '0;
    if (rst) begin
      rdy = '0;
    end else if (!bus.en) begin
      // Lock timer keeps running (saturating) while arbitration is paused.
      if ((state_q == ARB_LOCKED) && (lock_cnt_q < LOCK_MAX_C))
        lock_cnt_d = lock_cnt_q + CW'(1);
    end else if (hold_mode) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
      if (bus.req_v[owner_q]) begin
        rdy[owner_q] = 1'b1;
        areg_w_d     = 1'b1;
        ptr_d        = owner_q;
      end
    end else begin
      state_d    = ARB_IDLE;
      lock_cnt_d = '0;
      if (pick_any) begin
        rdy      = pick_grant;
        areg_w_d = 1'b1;
        ptr_d    = pick_idx;
        if (bus.req_lock[pick_idx]) begin
          state_d    = ARB_LOCKED;
          owner_d    = pick_idx;
          lock_cnt_d = CW'(1);
        end
      end
    end
    if (areg_w_d) begin
      areg_y_d    = sel_y;
      areg_wa_d   = sel_wa;
      areg_wval_d = sel_wval;
    end
  end

  // State and the registered areg write bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      ptr_q       <= PW'(NREQ - 1);
      lock_cnt_q  <= '0;
      areg_w_q    <= 1'b0;
      areg_y_q    <= 1'b0;
      areg_wa_q   <= '0;
      areg_wval_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      areg_w_q    <= areg_w_d;
      areg_y_q    <= areg_y_d;
      areg_wa_q   <= areg_wa_d;
      areg_wval_q <= areg_wval_d;
    end
  end

  assign bus.req_rdy   = rdy;
  assign bus.areg_w    = areg_w_q;
  assign bus.areg_y    = areg_y_q;
  assign bus.areg_wa   = areg_wa_q;
  assign bus.areg_wval = areg_wval_q;
  assign bus.owner     = owner_q;
  assign bus.locked    = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_areg_wr_arb.sv
// Bench for areg_wr_arb: directed tables/sequences plus random traffic
// against a behavioural arbitration model and a small areg contents model.
module tb_areg_wr_arb;
  import areg_wr_arb_pkg::*;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 16;
  localparam int LOCK_MAX = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  areg_wr_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  areg_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit                 m_locked;
  int                 m_owner, m_cnt, m_ptr;
  bit                 m_w, m_y;
  logic [3:0]         m_wa;
  logic [WIDTH-1:0]   m_wval;
  logic [WIDTH-1:0]   mem [NREGS];

  typedef struct {
    logic       en;
    logic [3:0] v;
    logic [3:0] l;
    logic [3:0] exp_rdy;
    logic       exp_w;
    logic [3:0] exp_wa;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = NREQ - 1;
    m_w = 0; m_y = 0; m_wa = 0; m_wval = 0;
  endtask

  // Closest valid requester going round from ptr+1.
  function automatic int pick_winner(logic [NREQ-1:0] elig, int ptr);
    int best = -1;
    int bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      int d = (i - ptr - 1 + 2 * NREQ) % NREQ;
      if (elig[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic model_plan(output int g, output bit holding);
    logic [NREQ-1:0] elig;
    g = -1;
    holding = m_locked && bus.req_lock[m_owner] && (m_cnt < LOCK_MAX);
    if (rst || !bus.en) return;
    if (holding) begin
      if (bus.req_v[m_owner]) g = m_owner;
    end else begin
      elig = bus.req_v;
      if (m_locked && m_cnt >= LOCK_MAX) elig[m_owner] = 1'b0;
      g = pick_winner(elig, m_ptr);
    end
  endtask

  // One clock: compare everything against the model, then advance both.
  task automatic do_cycle(input string tag);
    int g;
    bit holding;
    logic [NREQ-1:0] erdy;
    logic cw, cy;
    logic [3:0] cwa;
    logic [WIDTH-1:0] cwval, nv;
    #1;
    model_plan(g, holding);
    erdy = (g >= 0) ? NREQ'(1 << g) : '0;
    chk({tag, " rdy"}, 64'(bus.req_rdy), 64'(erdy));
    chk({tag, " w"}, 64'(bus.areg_w), 64'(m_w));
    chk({tag, " y"}, 64'(bus.areg_y), 64'(m_y));
    chk({tag, " wa"}, 64'(bus.areg_wa), 64'(m_wa));
    chk({tag, " wval"}, 64'(bus.areg_wval), 64'(m_wval));
    chk({tag, " locked"}, 64'(bus.locked), 64'(m_locked));
    if (m_locked) chk({tag, " owner"}, 64'(bus.owner), 64'(m_owner));
    cw = bus.areg_w; cy = bus.areg_y; cwa = bus.areg_wa; cwval = bus.areg_wval;
    @(posedge clk);
    // areg contents: overwrite or accumulate, low half mirrored upward
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] = '0;
    end else if (cw) begin
      nv = cy ? cwval : mem[cwa] + cwval;
      mem[cwa] = nv;
      if (cwa < AREG_MIRROR) mem[cwa + AREG_MIRROR] = nv;
    end
    if (rst) begin
      model_reset();
    end else begin
      m_w = 0;
      if (!bus.en) begin
        if (m_locked && m_cnt < LOCK_MAX) m_cnt++;
      end else begin
        if (holding) m_cnt++;
        if (g >= 0) begin
          m_w = 1; m_y = bus.req_y[g];
          m_wa = bus.req_wa[4*g +: 4];
          m_wval = bus.req_wval[WIDTH*g +: WIDTH];
          m_ptr = g;
          if (!holding) begin
            if (bus.req_lock[g]) begin
              m_locked = 1; m_owner = g; m_cnt = 1;
            end else begin
              m_locked = 0; m_cnt = 0;
            end
          end
        end else if (!holding) begin
          m_locked = 0; m_cnt = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b1; bus.req_v = '1; bus.req_lock = '0;
    do_cycle("rst0");
    do_cycle("rst1");
    rst = 1'b0;
  endtask

  task automatic dir(input string tag, input logic [3:0] v, input logic [3:0] l,
                     input logic [3:0] exp_rdy);
    bus.en = 1'b1; bus.req_v = v; bus.req_lock = l;
    #1;
    chk({tag, " grant"}, 64'(bus.req_rdy), 64'(exp_rdy));
    do_cycle(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.req_v = '1; bus.req_y = '0; bus.req_lock = '0;
    bus.req_wa = 16'h4321; bus.req_wval = 64'h0004_0003_0002_0001;
    model_reset();
    for (int i = 0; i < NREGS; i++) mem[i] = '0;
    @(posedge clk);
    @(negedge clk);

    // reset with everything valid, then round-robin, en=0 pause, resume
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 1'b1, 4'd1};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 1'b1, 4'd2};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1, 4'd3};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b1, 4'd4};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 1'b1, 4'd1};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'd2};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd2};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd2};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd2};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'd2};
    tbl[11] = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 1'b0, 4'd2};
    tbl[12] = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1, 4'd3};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.en = tbl[i].en; bus.req_v = tbl[i].v; bus.req_lock = tbl[i].l;
      #1;
      chk($sformatf("tbl%0d rdy", i), 64'(bus.req_rdy), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d w", i), 64'(bus.areg_w), 64'(tbl[i].exp_w));
      chk($sformatf("tbl%0d wa", i), 64'(bus.areg_wa), 64'(tbl[i].exp_wa));
      do_cycle($sformatf("tbl%0d", i));
    end

    // accumulate chain into r3 (mirrored to r11)
    do_reset();
    bus.req_wa = 16'h4323; bus.req_y = 4'b0001; bus.req_wval[15:0] = 16'd5;
    dir("acc1", 4'b0001, 4'b0000, 4'b0001);
    bus.req_y = 4'b0000; bus.req_wval[15:0] = 16'd2;
    chk("acc1 out w", 64'(bus.areg_w), 64'd1);
    chk("acc1 out y", 64'(bus.areg_y), 64'd1);
    chk("acc1 out wval", 64'(bus.areg_wval), 64'd5);
    dir("acc2", 4'b0001, 4'b0000, 4'b0001);
    chk("acc2 out y", 64'(bus.areg_y), 64'd0);
    chk("acc2 out wa", 64'(bus.areg_wa), 64'd3);
    chk("acc2 out wval", 64'(bus.areg_wval), 64'd2);
    dir("acc3", 4'b0000, 4'b0000, 4'b0000);
    chk("acc r3", 64'(mem[3]), 64'd7);
    chk("acc r11", 64'(mem[11]), 64'd7);
    bus.req_wa = 16'h4321; bus.req_wval = 64'h0004_0003_0002_0001;

    // lock by requester 1, idle owner blocks others, drop hands to 2
    do_reset();
    dir("lk0", 4'b0010, 4'b0010, 4'b0010);
    chk("lk0 locked", 64'(bus.locked), 64'd1);
    chk("lk0 owner", 64'(bus.owner), 64'd1);
    dir("lk1", 4'b0111, 4'b0010, 4'b0010);
    dir("lk2", 4'b0101, 4'b0010, 4'b0000);
    dir("lk3", 4'b0111, 4'b0010, 4'b0010);
    dir("lk4", 4'b0111, 4'b0000, 4'b0100);
    chk("lk5 unlocked", 64'(bus.locked), 64'd0);

    // lock expiry after LOCK_MAX owner cycles; owner excluded at expiry
    do_reset();
    dir("ex1", 4'b0100, 4'b0100, 4'b0100);
    for (int k = 2; k <= LOCK_MAX; k++)
      dir($sformatf("ex%0d", k), 4'b1100, 4'b0100, 4'b0100);
    chk("ex owner", 64'(bus.owner), 64'd2);
    dir("ex9", 4'b1100, 4'b0100, 4'b1000);
    chk("ex9 unlocked", 64'(bus.locked), 64'd0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.en = ($urandom_range(0, 9) != 0);
      bus.req_v = 4'($urandom);
      bus.req_y = 4'($urandom);
      bus.req_lock = 4'($urandom | $urandom);
      bus.req_wa = 16'($urandom);
      bus.req_wval = {$urandom, $urandom};
      do_cycle($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
